// File: rtl/dt_pkg.sv
// Shared types and widths for the decision-tree traversal block.
package dt_pkg;

   localparam int unsigned ADDR_W     = 9;
   localparam int unsigned FEAT_W     = 64;
   localparam int unsigned CLASS_W    = 2;
   localparam int unsigned FIDX_W     = 2;
   localparam int unsigned NUM_FEAT   = 4;
   localparam int unsigned DEPTH_W    = 6;
   localparam int unsigned NODE_WIDTH = 95;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Node record as returned by tree_memory (leaf flag travels separately).
   typedef struct packed {
      logic [ADDR_W-1:0]  id;
      logic [FIDX_W-1:0]  feature_idx;
      logic [FEAT_W-1:0]  threshold;
      logic [ADDR_W-1:0]  left_child;
      logic [ADDR_W-1:0]  right_child;
      logic [CLASS_W-1:0] prediction;
   } node_t;

endpackage

// File: rtl/dt_node_eval.sv
// Combinational node evaluation: pick a feature, compare, choose a child.
module dt_node_eval
   import dt_pkg::*;
(
   input  logic [NUM_FEAT*FEAT_W-1:0] features_i,
   input  logic [FIDX_W-1:0]          feature_idx_i,
   input  logic [FEAT_W-1:0]          threshold_i,
   input  logic [ADDR_W-1:0]          left_i,
   input  logic [ADDR_W-1:0]          right_i,
   output logic [ADDR_W-1:0]          next_addr_o,
   output logic                       go_left_o
);

   logic [FEAT_W-1:0] sel;

   // Unsigned compare; equality goes left.
   always_comb begin
      sel         = features_i[32'(feature_idx_i)*FEAT_W +: FEAT_W];
      go_left_o   = (sel <= threshold_i);
      next_addr_o = go_left_o ? left_i : right_i;
   end

endmodule

// File: rtl/tree_traversal_fsm.sv
// Decision-tree inference controller driving tree_memory.
// Optional macro TRAV_STATS_EN adds saturating inference/error counters.
module tree_traversal_fsm #(
   parameter int unsigned ADDR_W    = dt_pkg::ADDR_W,
   parameter int unsigned NUM_NODES = 512,
   parameter int unsigned ROOT_ADDR = 0,
   parameter int unsigned MAX_DEPTH = 32,
   parameter int unsigned FEAT_W    = dt_pkg::FEAT_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          feat_valid,
   output logic                          feat_ready,
   input  logic [4*FEAT_W-1:0]           features,
   output logic                          mem_read_enable,
   output logic [ADDR_W-1:0]             mem_node_addr,
   input  logic [ADDR_W-1:0]             mem_node_id,
   input  logic [dt_pkg::FIDX_W-1:0]     mem_feature_idx,
   input  logic [FEAT_W-1:0]             mem_threshold,
   input  logic [ADDR_W-1:0]             mem_left_child,
   input  logic [ADDR_W-1:0]             mem_right_child,
   input  logic [dt_pkg::CLASS_W-1:0]    mem_prediction,
   input  logic                          mem_is_leaf,
   input  logic                          mem_data_valid,
   output logic                          pred_valid,
   input  logic                          pred_ready,
   output logic [dt_pkg::CLASS_W-1:0]    pred_class,
   output logic [dt_pkg::DEPTH_W-1:0]    pred_depth,
   output logic                          pred_error,
   output logic                          busy
`ifdef TRAV_STATS_EN
   ,
   output logic [31:0]                   stat_infer_cnt,
   output logic [15:0]                   stat_err_cnt
`endif
);

   import dt_pkg::*;

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
   logic [DEPTH_W-1:0]     depth_q, depth_d, depth_inc;
   logic [4*FEAT_W-1:0]    feat_q, feat_d;
   logic [CLASS_W-1:0]     class_q, class_d;
   logic                   err_q, err_d;
   logic                   rd_en_q, valid_q, busy_q, ready_q;
   node_t                  node_c;
   logic [ADDR_W-1:0]      next_addr_c;
   logic                   go_left_c;

   assign node_c = '{id:          mem_node_id,
                     feature_idx: mem_feature_idx,
                     threshold:   mem_threshold,
                     left_child:  mem_left_child,
                     right_child: mem_right_child,
                     prediction:  mem_prediction};

   dt_node_eval u_eval (
      .features_i    (feat_q),
      .feature_idx_i (node_c.feature_idx),
      .threshold_i   (node_c.threshold),
      .left_i        (node_c.left_child),
      .right_i       (node_c.right_child),
      .next_addr_o   (next_addr_c),
      .go_left_o     (go_left_c)
   );

   // Next-state and walk bookkeeping.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      depth_d    = depth_q;
      feat_d     = feat_q;
      class_d    = class_q;
      err_d      = err_q;
      depth_inc  = DEPTH_W'(depth_q + 1'b1);
      unique case (state_q)
         IDLE: begin
            if (feat_valid && ready_q) begin
               feat_d     = features;
               cur_addr_d = ADDR_W'(ROOT_ADDR);
               depth_d    = '0;
               class_d    = '0;
               err_d      = 1'b0;
               state_d    = FETCH;
            end
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            if (mem_data_valid) begin
               if (node_c.id != cur_addr_q) begin
                  err_d   = 1'b1;
                  class_d = '0;
                  state_d = DONE;
               end else if (mem_is_leaf) begin
                  err_d   = 1'b0;
                  class_d = node_c.prediction;
                  state_d = DONE;
               end else begin
                  depth_d = depth_inc;
                  if ((32'(next_addr_c) >= NUM_NODES) || (32'(depth_inc) > MAX_DEPTH)) begin
                     err_d   = 1'b1;
                     class_d = '0;
                     state_d = DONE;
                  end else begin
                     cur_addr_d = next_addr_c;
                     state_d    = FETCH;
                  end
               end
            end
         end
         DONE: if (pred_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered outputs aligned to the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         depth_q    <= '0;
         feat_q     <= '0;
         class_q    <= '0;
         err_q      <= 1'b0;
         rd_en_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         depth_q    <= depth_d;
         feat_q     <= feat_d;
         class_q    <= class_d;
         err_q      <= err_d;
         rd_en_q    <= (state_d == FETCH);
         valid_q    <= (state_d == DONE);
         busy_q     <= (state_d != IDLE);
         ready_q    <= (state_d == IDLE);
      end
   end

   assign feat_ready      = ready_q;
   assign mem_read_enable = rd_en_q;
   assign mem_node_addr   = cur_addr_q;
   assign pred_valid      = valid_q;
   assign pred_class      = class_q;
   assign pred_depth      = depth_q;
   assign pred_error      = err_q;
   assign busy            = busy_q;

`ifdef TRAV_STATS_EN
   logic [31:0] infer_cnt_q;
   logic [15:0] err_cnt_q;

   // Saturating counters of completed handshakes and errored ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infer_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else if (valid_q && pred_ready) begin
         if (infer_cnt_q != '1) infer_cnt_q <= infer_cnt_q + 32'd1;
         if (err_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign stat_infer_cnt = infer_cnt_q;
   assign stat_err_cnt   = err_cnt_q;
`endif

endmodule
